// File: rtl/audio_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : audio_sync_sched
// Purpose  : Round-robin scheduler sharing one audio sample path between NSRC
//            sources. Each published word is held for at least HOLD cycles
//            so the downstream synchroniser sees a stable value.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            src_en          - per-source enable mask
//            src_valid       - per-source sample pending
//            src_data        - packed samples, source i at [i*AUDIO_DW +: AUDIO_DW]
//            src_ready       - registered one-hot grant (one cycle, LOAD)
//            dout, dout_chan - published sample and its source index
//            dout_stb        - one-cycle pulse when dout/dout_chan change
//            busy            - high whenever the scheduler is not idle
// Revision : 1.0 - initial release
// ============================================================================
module audio_sync_sched #(
  parameter int AUDIO_DW = 16,
  parameter int NSRC     = 4,
  parameter int HOLD     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src_en,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [NSRC*AUDIO_DW-1:0] src_data,
  output logic [NSRC-1:0]          src_ready,
  output logic [AUDIO_DW-1:0]      dout,
  output logic [$clog2(NSRC)-1:0]  dout_chan,
  output logic                     dout_stb,
  output logic                     busy
);

  localparam int IW = $clog2(NSRC);
  localparam int CW = $clog2(HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [NSRC-1:0]     eligible;
  logic [IW-1:0]       pick;
  logic                any_elig;
  logic                xfer;
  logic [AUDIO_DW-1:0] src_word [NSRC];

  // Index p+k wrapped into 0..NSRC-1 (NSRC need not be a power of two).
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NSRC) s = s - NSRC;
    return IW'(s);
  endfunction

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
      assign src_word[i] = src_data[i*AUDIO_DW +: AUDIO_DW];
    end
  endgenerate

  assign eligible = src_valid & src_en;
  assign xfer     = src_valid[g];
  assign busy     = (state != S_IDLE);

  // Search from ptr upward; iterating downward lets the lowest offset win.
  always_comb begin
    pick     = ptr;
    any_elig = 1'b0;
    for (int k = NSRC-1; k >= 0; k--) begin
      if (eligible[rot_idx(ptr, k)]) begin
        pick     = rot_idx(ptr, k);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (any_elig) state_n = S_LOAD;
      S_LOAD:  state_n = xfer ? S_HOLD : S_IDLE;
      S_HOLD:  if (cnt == '0) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_ready <= '0;
      dout      <= '0;
      dout_chan <= '0;
      dout_stb  <= 1'b0;
      g         <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      src_ready <= '0;
      dout_stb  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            g         <= pick;
            src_ready <= NSRC'(1) << pick;
          end
        end
        S_LOAD: begin
          // A dropped valid simply abandons the slot; ptr stays put.
          if (xfer) begin
            dout      <= src_word[g];
            dout_chan <= g;
            dout_stb  <= 1'b1;
            ptr       <= rot_idx(g, 1);
            cnt       <= CW'(HOLD-1);
          end
        end
        S_HOLD: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_sync_sched
// Purpose  : Self-checking bench for audio_sync_sched (default build plus a
//            HOLD=2 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sync_sched;

  localparam int DW   = 16;
  localparam int NSRC = 4;
  localparam int HOLD = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      src_en = '0, src_valid = '0;
  logic [63:0]     src_data = '0;
  logic [3:0]      src_ready;
  logic [15:0]     dout;
  logic [1:0]      dout_chan;
  logic            dout_stb, busy;

  logic [3:0]      en2 = '0, valid2 = '0;
  logic [63:0]     data2 = '0;
  logic [3:0]      rdy2;
  logic [15:0]     dout2;
  logic [1:0]      chan2;
  logic            stb2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_sync_sched #(.AUDIO_DW(DW), .NSRC(NSRC), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .src_en(src_en), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .dout(dout),
    .dout_chan(dout_chan), .dout_stb(dout_stb), .busy(busy)
  );

  audio_sync_sched #(.AUDIO_DW(DW), .NSRC(NSRC), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .src_en(en2), .src_valid(valid2),
    .src_data(data2), .src_ready(rdy2), .dout(dout2),
    .dout_chan(chan2), .dout_stb(stb2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (default build) ----------------
  // age: -1 idle, 0 grant cycle, 1..HOLD hold cycles after the strobe.
  int          m_age = -1, m_g = 0, m_ptr = 0, m_chan = 0;
  logic [15:0] m_dout = '0;
  logic        m_stb = 1'b0;
  logic [3:0]  m_ready = '0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin : model
    int age, gi, p, ch, idx;
    logic [15:0] d;
    logic [3:0]  rdy;
    logic        stb;
    bit          found;
    age = m_age; gi = m_g; p = m_ptr; ch = m_chan; d = m_dout;
    rdy = '0; stb = 1'b0; found = 1'b0;
    if (rst) begin
      age = -1; gi = 0; p = 0; ch = 0; d = '0;
    end else if (age < 0) begin
      for (int k = 0; k < NSRC; k++) begin
        idx = (p + k) % NSRC;
        if (!found && src_valid[idx] && src_en[idx]) begin
          found = 1'b1;
          gi    = idx;
        end
      end
      if (found) begin
        age     = 0;
        rdy[gi] = 1'b1;
      end
    end else if (age == 0) begin
      if (src_valid[gi]) begin
        d   = src_data[gi*16 +: 16];
        ch  = gi;
        stb = 1'b1;
        p   = (gi + 1) % NSRC;
        age = 1;
      end else begin
        age = -1;
      end
    end else begin
      age = age + 1;
      if (age > HOLD) age = -1;
    end
    m_age   <= age;
    m_g     <= gi;
    m_ptr   <= p;
    m_chan  <= ch;
    m_dout  <= d;
    m_stb   <= stb;
    m_ready <= rdy;
    m_live  <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_ready", 32'(src_ready), 32'(m_ready));
      chk("cmp_dout",  32'(dout),      32'(m_dout));
      chk("cmp_chan",  32'(dout_chan), 32'(m_chan));
      chk("cmp_stb",   32'(dout_stb),  32'(m_stb));
      chk("cmp_busy",  32'(busy),      32'(m_age >= 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_stb(input bit second, input string tag, output int at, output int ch);
    at = -1; ch = -1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if ((second ? stb2 : dout_stb) === 1'b1) begin
        at = cyc;
        ch = second ? int'(chan2) : int'(dout_chan);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: no strobe within 40 cycles", tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) return;
      step(1);
    end
    checks++; errors++;
    $display("FAIL %s: busy never dropped", tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  int exp_s2 [5] = '{0, 1, 2, 3, 0};
  int exp_s3 [4] = '{0, 1, 3, 0};

  initial begin
    int at, ch, prev;

    // Reset state
    step(3);
    chk("rst_ready", 32'(src_ready), 32'h0);
    chk("rst_dout",  32'(dout),      32'h0);
    chk("rst_chan",  32'(dout_chan), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    rst = 1'b0;

    // Single request from source 0
    src_en = 4'b1111;
    src_data[15:0] = 16'h1234;
    src_valid = 4'b0001;
    step(1);
    chk("s1_ready", 32'(src_ready), 32'h1);
    step(1);
    chk("s1_dout", 32'(dout), 32'h1234);
    chk("s1_chan", 32'(dout_chan), 32'h0);
    chk("s1_stb",  32'(dout_stb), 32'h1);
    src_valid = 4'b0000;
    step(7);
    chk("s1_busy_t9", 32'(busy), 32'h1);
    step(1);
    chk("s1_busy_t10", 32'(busy), 32'h0);

    // All four valid: round robin 0,1,2,3,0 with 10-cycle spacing
    do_reset();
    for (int i = 0; i < 4; i++) src_data[i*16 +: 16] = 16'hA000 + 16'(i);
    src_valid = 4'b1111;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      wait_stb(1'b0, "s2_stb", at, ch);
      chk("s2_chan", 32'(ch), 32'(exp_s2[i]));
      chk("s2_dout", 32'(dout), 32'(16'hA000 + 16'(exp_s2[i])));
      if (i > 0) chk("s2_gap", 32'(at - prev), 32'd10);
      prev = at;
    end
    src_valid = 4'b0000;
    wait_idle("s2_idle");

    // Source 2 disabled
    do_reset();
    src_en    = 4'b1011;
    src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_stb(1'b0, "s3_stb", at, ch);
      chk("s3_chan", 32'(ch), 32'(exp_s3[i]));
    end
    src_valid = 4'b0000;
    wait_idle("s3_idle");   // ptr now 1

    // Failed LOAD on source 1 leaves ptr at 1
    src_en = 4'b1111;
    src_data[31:16] = 16'h5A5A;
    src_valid = 4'b0010;
    step(1);
    chk("s4_ready", 32'(src_ready), 32'h2);
    src_valid = 4'b0000;
    step(1);
    chk("s4_nostb", 32'(dout_stb), 32'h0);
    chk("s4_dout_kept", 32'(dout), 32'hA000);
    chk("s4_idle", 32'(busy), 32'h0);
    src_valid = 4'b0011;
    step(1);
    chk("s4_regrant", 32'(src_ready), 32'h2);
    step(1);
    chk("s4_dout", 32'(dout), 32'h5A5A);
    chk("s4_chan", 32'(dout_chan), 32'h1);
    src_valid = 4'b0000;
    wait_idle("s4_idle2");  // ptr now 2

    // Reset in the 4th HOLD cycle
    src_data[31:16] = 16'h1111;
    src_valid = 4'b0010;
    step(2);
    chk("s5_stb", 32'(dout_stb), 32'h1);
    src_valid = 4'b0000;
    step(3);
    rst = 1'b1;
    step(1);
    chk("s5_dout", 32'(dout), 32'h0);
    chk("s5_chan", 32'(dout_chan), 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    chk("s5_ready", 32'(src_ready), 32'h0);
    rst = 1'b0;
    src_valid = 4'b0101;
    step(1);
    chk("s5_grant0", 32'(src_ready), 32'h1);
    step(1);
    chk("s5_dout2", 32'(dout), 32'hA000);
    src_valid = 4'b0000;
    wait_idle("s5_idle");

    // HOLD=2 build, source 3 alone
    en2 = 4'b1111;
    data2[63:48] = 16'hC3C3;
    valid2 = 4'b1000;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_stb(1'b1, "s6_stb", at, ch);
      chk("s6_chan", 32'(ch), 32'h3);
      chk("s6_dout", 32'(dout2), 32'hC3C3);
      if (i > 0) chk("s6_gap", 32'(at - prev), 32'd4);
      prev = at;
    end
    valid2 = 4'b0000;
    step(5);
    chk("s6_idle", 32'(busy2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_sync_sched.md
# audio_sync_sched

Round-robin scheduler that shares one audio sample path between several audio sources (beeper, AY/PSG, DAC, etc.) and drives the multi-bit word that feeds the downstream audio synchroniser. That synchroniser only accepts a word once it has been stable for consecutive samples in the destination domain. This block therefore guarantees every published word is held unchanged for a programmable minimum number of cycles before the next one may replace it. Each source gets a valid/ready handshake and fair access.

## Interface

Parameters:
- AUDIO_DW, 16, sample width in bits.
- NSRC, 4, number of requesting sources (2..8).
- HOLD, 8, minimum cycles a published word stays in HOLD state (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- src_en  input  NSRC  per-source enable mask; a disabled source is never granted.
- src_valid  input  NSRC  source i has a sample pending.
- src_data  input  NSRC*AUDIO_DW  source i sample in bits [i*AUDIO_DW +: AUDIO_DW].
- src_ready  output  NSRC  registered one-hot grant, high for exactly one cycle (LOAD).
- dout  output  AUDIO_DW  registered published sample, to the synchroniser.
- dout_chan  output  clog2(NSRC)  index of the source that supplied dout.
- dout_stb  output  1  one-cycle pulse in the cycle dout/dout_chan change.
- busy  output  1  high whenever state ≠ IDLE.

## Operation

- State machine: IDLE, LOAD, HOLD. Registers: state, grant index g, round-robin pointer ptr, hold counter cnt (clog2(HOLD) bits).
- IDLE: eligible[i] = src_valid[i] & src_en[i]. If any are eligible, g ← first eligible index searching ptr, ptr+1, … modulo NSRC; src_ready ← one-hot(g); go to LOAD. Otherwise stay.
- LOAD: src_ready[g] is high this cycle only. A transfer occurs iff src_valid[g] is also high.
  - On transfer: dout ← src_data[g], dout_chan ← g, dout_stb ← 1, ptr ← (g+1) mod NSRC, cnt ← HOLD-1, go to HOLD.
  - If src_valid[g] is low: no update and ptr unchanged; go to IDLE. src_en changes in LOAD are ignored.
- HOLD: dout is frozen. If cnt = 0, go to IDLE; else cnt ← cnt-1. Requests are ignored; src_ready is all-zero.
- Sources must hold src_data stable while src_valid is high, and may deassert src_valid only after a transfer or while src_ready is low.
- Reset (any state, including mid-LOAD or mid-HOLD): state ← IDLE, src_ready ← 0, dout ← 0, dout_chan ← 0, dout_stb ← 0, ptr ← 0, cnt ← 0, busy ← 0. A LOAD cycle interrupted by reset is not a transfer.
- All outputs are registered (no combinational path from inputs to outputs).

## Timing

- Request first eligible in IDLE at cycle t → src_ready high at t+1 → dout, dout_chan, dout_stb updated at t+2.
- HOLD occupies cycles t+2 … t+HOLD+1; IDLE at t+HOLD+2.
- Minimum spacing between dout_stb pulses is HOLD+2 cycles (10 with defaults).
- A source still valid after its transfer waits at least one full rotation if other eligible sources exist.
- Simultaneous requests from all sources are served in index order from ptr, one per slot; no source waits more than NSRC slots.
- ptr wraps from NSRC-1 to 0.
- A failed LOAD (valid dropped) costs 2 cycles and leaves ptr unchanged.
- dout is constant for ≥ HOLD+2 cycles after every change.

## Test plan

- Reset, then src0 valid with data 0x1234, all enabled → src_ready=0001 at t+1; dout=0x1234, dout_chan=0, dout_stb=1 at t+2; busy low at t+10.
- All four valid continuously with data 0xA000+i → dout_chan sequence 0,1,2,3,0, with strobes exactly 10 cycles apart and dout stable between strobes.
- src_en=1011 with all valid → source 2 is never granted; chan sequence 0,1,3,0.
- src1 alone valid; drop src_valid[1] in its LOAD cycle → no strobe, dout unchanged, ptr still 1; next request from src1 is granted.
- Assert rst in the 4th HOLD cycle → next cycle dout=0, dout_chan=0, busy=0, src_ready=0; a fresh request is then granted from src0.
- HOLD=2 build, src3 continuously valid alone → strobes every 4 cycles, dout_chan=3, ptr wraps to 0 after each grant.
